drv_fifo_port: RTL and testbench

- Per-device FIFO endpoint that sits directly on one driver slot of bs_gnrtr_n_rbtr.
- Transmit side: a first-word-fall-through (FWFT) FIFO. It presents pndng/D_pop to the bus driver and consumes pop.
- Receive side: a FIFO that captures push/D_push from the bus driver and hands words to a local consumer over a valid/ready handshake.
- One instance per driver; the DRVS instances are concatenated into the bus driver's packed pndng/pop/D_pop/push/D_push vectors.

---
 rtl/drv_fifo_port.sv | 144 ++++++++++++++
 tb/tb_drv_fifo_port.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drv_fifo_port.sv
// drv_fifo_port: per-driver FIFO endpoint for one slot of bs_gnrtr_n_rbtr.
// TX side is a first-word-fall-through FIFO feeding the bus driver (pndng/D_pop/pop).
// RX side captures push/D_push and hands words to a local valid/ready consumer.
// Sticky error flags and a saturating drop counter report protocol misuse.
module drv_fifo_port #(
  parameter int width = 16,
  parameter int depth = 8,
  parameter int cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  // local producer -> TX FIFO
  input  logic             tx_valid,
  input  logic [width-1:0] tx_data,
  output logic             tx_ready,
  // TX FIFO -> bus driver
  output logic             pndng,
  input  logic             pop,
  output logic [width-1:0] D_pop,
  // bus driver -> RX FIFO
  input  logic             push,
  input  logic [width-1:0] D_push,
  // RX FIFO -> local consumer
  output logic             rx_valid,
  output logic [width-1:0] rx_data,
  input  logic             rx_ready,
  // status
  output logic [cnt_w-1:0] tx_count,
  output logic [cnt_w-1:0] rx_count,
  output logic             tx_underflow,
  output logic             rx_overflow,
  output logic [7:0]       rx_drop_cnt,
  input  logic             clear_err
);

  localparam int ptr_w = $clog2(depth);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  // ---------------------------------------------------------------------------
  // TX FIFO state
  // ---------------------------------------------------------------------------
  logic [width-1:0] r_tx_mem [depth];
  logic [ptr_w-1:0] r_tx_wr_ptr;
  logic [ptr_w-1:0] r_tx_rd_ptr;
  logic [cnt_w-1:0] r_tx_cnt;
  logic             r_tx_underflow;

  logic w_tx_push;
  logic w_tx_pop;
  logic w_tx_uf_evt;

  // Fullness and emptiness are judged on registered occupancy only, so there is
  // no combinational path from pop to tx_ready; an empty FIFO never bypasses.
  assign w_tx_push   = tx_valid && (r_tx_cnt != full_cnt);
  assign w_tx_pop    = pop && (r_tx_cnt != '0);
  assign w_tx_uf_evt = pop && (r_tx_cnt == '0);

  // TX storage write; data is only observable through the occupancy counter.
  // NOTE: storage arrays carry no reset -- stale entries are unreachable once the
  // counter is cleared, and leaving them unreset lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= tx_data;
  end

  // TX pointers, occupancy and underflow flag.
  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wr_ptr    <= '0;
      r_tx_rd_ptr    <= '0;
      r_tx_cnt       <= '0;
      r_tx_underflow <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + ptr_w'(1);
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + ptr_w'(1);
      r_tx_cnt <= r_tx_cnt + cnt_w'(w_tx_push) - cnt_w'(w_tx_pop);
      // A coincident underflow beats clear_err so the event is never lost.
      if (w_tx_uf_evt)    r_tx_underflow <= 1'b1;
      else if (clear_err) r_tx_underflow <= 1'b0;
    end
  end

  assign tx_ready     = (r_tx_cnt != full_cnt);
  assign pndng        = (r_tx_cnt != '0);
  assign D_pop        = pndng ? r_tx_mem[r_tx_rd_ptr] : '0;
  assign tx_count     = r_tx_cnt;
  assign tx_underflow = r_tx_underflow;

  // ---------------------------------------------------------------------------
  // RX FIFO state
  // ---------------------------------------------------------------------------
  logic [width-1:0] r_rx_mem [depth];
  logic [ptr_w-1:0] r_rx_wr_ptr;
  logic [ptr_w-1:0] r_rx_rd_ptr;
  logic [cnt_w-1:0] r_rx_cnt;
  logic             r_rx_overflow;
  logic [7:0]       r_rx_drop_cnt;

  logic w_rx_push;
  logic w_rx_pop;
  logic w_rx_drop;

  // A push into a full FIFO is dropped even if the consumer frees a slot on the
  // same edge: fullness is evaluated on the pre-edge occupancy.
  assign w_rx_push = push && (r_rx_cnt != full_cnt);
  assign w_rx_drop = push && (r_rx_cnt == full_cnt);
  assign w_rx_pop  = rx_ready && (r_rx_cnt != '0);

  // RX storage write.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= D_push;
  end

  // RX pointers, occupancy, overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wr_ptr   <= '0;
      r_rx_rd_ptr   <= '0;
      r_rx_cnt      <= '0;
      r_rx_overflow <= 1'b0;
      r_rx_drop_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + ptr_w'(1);
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + ptr_w'(1);
      r_rx_cnt <= r_rx_cnt + cnt_w'(w_rx_push) - cnt_w'(w_rx_pop);
      if (w_rx_drop) begin
        r_rx_overflow <= 1'b1;
        if (clear_err)                  r_rx_drop_cnt <= 8'd1;
        else if (r_rx_drop_cnt != 8'hFF) r_rx_drop_cnt <= r_rx_drop_cnt + 8'd1;
      end else if (clear_err) begin
        r_rx_overflow <= 1'b0;
        r_rx_drop_cnt <= '0;
      end
    end
  end

  assign rx_valid    = (r_rx_cnt != '0);
  assign rx_data     = rx_valid ? r_rx_mem[r_rx_rd_ptr] : '0;
  assign rx_count    = r_rx_cnt;
  assign rx_overflow = r_rx_overflow;
  assign rx_drop_cnt = r_rx_drop_cnt;

endmodule

// File: tb/tb_drv_fifo_port.sv
// tb_drv_fifo_port: directed test-plan sequences plus randomized traffic, all
// compared every cycle against a queue-based reference model of the endpoint.
module tb_drv_fifo_port;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             tx_valid = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_ready;
  logic             pndng;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] D_pop;
  logic             push = 1'b0;
  logic [WIDTH-1:0] D_push = '0;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready = 1'b0;
  logic [CNT_W-1:0] tx_count;
  logic [CNT_W-1:0] rx_count;
  logic             tx_underflow;
  logic             rx_overflow;
  logic [7:0]       rx_drop_cnt;
  logic             clear_err = 1'b0;

  drv_fifo_port #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .tx_underflow(tx_underflow), .rx_overflow(rx_overflow),
    .rx_drop_cnt(rx_drop_cnt), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two bounded queues plus error state.
  logic [WIDTH-1:0] m_txq[$];
  logic [WIDTH-1:0] m_rxq[$];
  bit               m_uf;
  bit               m_ov;
  int               m_drops;

  // Apply one clock edge's worth of behaviour using the inputs held this cycle.
  task automatic model_update();
    bit tx_full, rx_full, uf_evt, drop_evt;
    if (reset) begin
      m_txq.delete();
      m_rxq.delete();
      m_uf    = 0;
      m_ov    = 0;
      m_drops = 0;
      return;
    end
    tx_full  = (m_txq.size() == DEPTH);
    rx_full  = (m_rxq.size() == DEPTH);
    uf_evt   = pop && (m_txq.size() == 0);
    drop_evt = push && rx_full;
    if (pop && m_txq.size() > 0) void'(m_txq.pop_front());
    if (tx_valid && !tx_full) m_txq.push_back(tx_data);
    if (rx_ready && m_rxq.size() > 0) void'(m_rxq.pop_front());
    if (push && !rx_full) m_rxq.push_back(D_push);
    if (uf_evt) m_uf = 1;
    else if (clear_err) m_uf = 0;
    if (drop_evt) begin
      m_ov    = 1;
      m_drops = clear_err ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
    end else if (clear_err) begin
      m_ov    = 0;
      m_drops = 0;
    end
  endtask

  task automatic compare_all();
    check("pndng",    pndng,    m_txq.size() > 0);
    check("D_pop",    D_pop,    (m_txq.size() > 0) ? m_txq[0] : '0);
    check("tx_ready", tx_ready, m_txq.size() != DEPTH);
    check("tx_count", tx_count, m_txq.size());
    check("rx_valid", rx_valid, m_rxq.size() > 0);
    check("rx_data",  rx_data,  (m_rxq.size() > 0) ? m_rxq[0] : '0);
    check("rx_count", rx_count, m_rxq.size());
    check("tx_uf",    tx_underflow, m_uf);
    check("rx_ov",    rx_overflow,  m_ov);
    check("drop_cnt", rx_drop_cnt,  m_drops);
  endtask

  // One cycle: DUT and model both advance at posedge, outputs compared at negedge.
  // Callers change inputs only after tick returns (i.e. at the negedge).
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 0; tx_valid = 0; pop = 0; push = 0; rx_ready = 0; clear_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_pndng",    pndng,    1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_D_pop",    D_pop,    16'h0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data",  rx_data,  16'h0);

    // Three words through TX in order
    tx_valid = 1; tx_data = 16'hA001;
    tick();
    check("fwft_pndng", pndng, 1'b1);
    check("fwft_head",  D_pop, 16'hA001);
    tx_data = 16'hA002; tick();
    tx_data = 16'hA003; tick();
    tx_valid = 0; pop = 1;
    check("pop1", D_pop, 16'hA001); tick();
    check("pop2", D_pop, 16'hA002); tick();
    check("pop3", D_pop, 16'hA003); tick();
    pop = 0;
    check("drained_pndng", pndng,    1'b0);
    check("drained_D_pop", D_pop,    16'h0);
    check("drained_count", tx_count, 4'd0);

    // Fill TX, then a write while full alongside a pop
    tx_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      tx_data = 16'hB001 + 16'(i);
      tick();
    end
    check("full_ready", tx_ready, 1'b0);
    check("full_count", tx_count, 4'd8);
    tx_data = 16'hFFFF; pop = 1;
    tick();
    check("full_wr_count", tx_count, 4'd7);
    tx_valid = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      check("full_drain", D_pop, 16'hB002 + 16'(i));
      tick();
    end
    pop = 0;
    check("full_drain_empty", pndng, 1'b0);

    // RX fill, two overflow pushes, drain
    rx_ready = 0; push = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      D_push = 16'h0010 + 16'(i);
      tick();
    end
    push = 0;
    check("rx_ov_flag", rx_overflow, 1'b1);
    check("rx_drops2",  rx_drop_cnt, 8'd2);
    rx_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      check("rx_drain", rx_data, 16'h0010 + 16'(i));
      tick();
    end
    rx_ready = 0;
    check("rx_drain_empty", rx_valid, 1'b0);

    // Underflow, clear, clear racing a new underflow
    pop = 1; tick(); pop = 0;
    check("uf_set",   tx_underflow, 1'b1);
    check("uf_count", tx_count,     4'd0);
    clear_err = 1; tick(); clear_err = 0;
    check("uf_clear",   tx_underflow, 1'b0);
    check("ov_clear",   rx_overflow,  1'b0);
    check("drop_clear", rx_drop_cnt,  8'd0);
    clear_err = 1; pop = 1; tick(); clear_err = 0; pop = 0;
    check("uf_wins", tx_underflow, 1'b1);

    // Empty TX: write and pop together -> stored, underflow flagged
    clear_err = 1; tick(); clear_err = 0;
    tx_valid = 1; tx_data = 16'h5A5A; pop = 1; tick(); tx_valid = 0; pop = 0;
    check("nobypass_uf",   tx_underflow, 1'b1);
    check("nobypass_head", D_pop,        16'h5A5A);
    pop = 1; tick(); pop = 0;

    // Drop counter saturation, then clear coincident with a drop
    push = 1; D_push = 16'h0777;
    for (int i = 0; i < DEPTH + 260; i++) tick();
    check("drop_sat", rx_drop_cnt, 8'd255);
    clear_err = 1; tick(); clear_err = 0; push = 0;
    check("drop_clear_evt", rx_drop_cnt, 8'd1);
    check("ov_clear_evt",   rx_overflow, 1'b1);
    rx_ready = 1;
    for (int i = 0; i < DEPTH; i++) tick();
    rx_ready = 0;

    // Streaming 20 words with pop every cycle after the first write
    tx_valid = 1; tx_data = 16'hC000; tick();
    pop = 1;
    for (int i = 1; i < 20; i++) begin
      check("stream_out", D_pop, 16'hC000 + 16'(i - 1));
      tx_data = 16'hC000 + 16'(i);
      tick();
      check("stream_cnt_le1", 32'(tx_count <= 4'd1), 32'd1);
    end
    tx_valid = 0;
    check("stream_last", D_pop, 16'hC013);
    tick();
    pop = 0;
    check("stream_empty", pndng, 1'b0);

    // Reset with both FIFOs occupied
    tx_valid = 1;
    for (int i = 0; i < 5; i++) begin tx_data = 16'hD000 + 16'(i); tick(); end
    tx_valid = 0; push = 1;
    for (int i = 0; i < 3; i++) begin D_push = 16'hE000 + 16'(i); tick(); end
    push = 0;
    do_reset();
    check("mid_rst_pndng", pndng,    1'b0);
    check("mid_rst_rxv",   rx_valid, 1'b0);
    check("mid_rst_txc",   tx_count, 4'd0);
    check("mid_rst_rxc",   rx_count, 4'd0);
    check("mid_rst_dpop",  D_pop,    16'h0);
    check("mid_rst_ready", tx_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      tx_valid  = ($urandom_range(0, 3) != 0);
      tx_data   = 16'($urandom);
      pop       = ($urandom_range(0, 2) == 0);
      push      = ($urandom_range(0, 1) == 0);
      D_push    = 16'($urandom);
      rx_ready  = ($urandom_range(0, 2) == 0);
      clear_err = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
